// File: rtl/pc_gen_if.sv
// Fetch-side bus of the PC generator: control, redirect, BTB update inputs
// and the fetch PC / prediction outputs.
interface pc_gen_if #(
  parameter int ADDR_W  = 32,
  parameter int STALL_W = 6
);
  // No back-pressure on this bus: upd_valid_in is a single-cycle strobe that
  // takes effect on any rising edge where rdy_in=1; there is no ready return.
  logic               rdy_in;
  logic [STALL_W-1:0] stall;
  logic               branch_flag_in;
  logic [ADDR_W-1:0]  branch_target_addr_in;
  logic               upd_valid_in;
  logic [ADDR_W-1:0]  upd_pc_in;
  logic [ADDR_W-1:0]  upd_target_in;
  logic               upd_taken_in;
  logic [ADDR_W-1:0]  pc_out;
  logic               pred_taken_out;
  logic [ADDR_W-1:0]  pred_target_out;

  modport master (
    output rdy_in, stall, branch_flag_in, branch_target_addr_in,
    output upd_valid_in, upd_pc_in, upd_target_in, upd_taken_in,
    input  pc_out, pred_taken_out, pred_target_out
  );

  modport slave (
    input  rdy_in, stall, branch_flag_in, branch_target_addr_in,
    input  upd_valid_in, upd_pc_in, upd_target_in, upd_taken_in,
    output pc_out, pred_taken_out, pred_target_out
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch PC generator with a direct-mapped BTB and 2-bit saturating counters.
// BTB_DEPTH must be a power of two, at least 2.
module pc_gen #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int                BTB_DEPTH = 16,
  parameter int                STALL_W   = 6
) (
  input logic     clk_in,
  input logic     rst_in,
  pc_gen_if.slave bus
);
  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;

  logic              btb_valid  [BTB_DEPTH];
  logic [TAG_W-1:0]  btb_tag    [BTB_DEPTH];
  logic [ADDR_W-1:0] btb_target [BTB_DEPTH];
  logic [1:0]        btb_cnt    [BTB_DEPTH];

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic [IDX_W-1:0]  look_idx;
  logic [TAG_W-1:0]  look_tag;
  logic              look_hit;
  logic [IDX_W-1:0]  upd_idx;
  logic [TAG_W-1:0]  upd_tag;
  logic              upd_hit;
  logic              upd_en;

  logic unused_bits;
  assign unused_bits = ^{bus.stall[STALL_W-1:1], bus.upd_pc_in[1:0]};

  // Lookup on the registered PC
  assign look_idx = pc[2+IDX_W-1:2];
  assign look_tag = pc[ADDR_W-1:2+IDX_W];
  assign look_hit = btb_valid[look_idx] && (btb_tag[look_idx] == look_tag);

  assign bus.pc_out          = pc;
  assign bus.pred_taken_out  = look_hit && btb_cnt[look_idx][1];
  assign bus.pred_target_out = btb_target[look_idx];

  always_comb begin
    pc_next = pc;
    if (!bus.rdy_in) begin
      pc_next = pc;
    end else if (bus.branch_flag_in) begin
      pc_next = {bus.branch_target_addr_in[ADDR_W-1:2], 2'b00};
    end else if (bus.stall[0]) begin
      pc_next = pc;
    end else if (bus.pred_taken_out) begin
      pc_next = {bus.pred_target_out[ADDR_W-1:2], 2'b00};
    end else begin
      pc_next = pc + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      pc <= {RESET_VEC[ADDR_W-1:2], 2'b00};
    end else begin
      pc <= pc_next;
    end
  end

  // Update side: stall and redirect do not gate training, only rdy_in does
  assign upd_idx = bus.upd_pc_in[2+IDX_W-1:2];
  assign upd_tag = bus.upd_pc_in[ADDR_W-1:2+IDX_W];
  assign upd_hit = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);
  assign upd_en  = bus.rdy_in && bus.upd_valid_in;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        btb_valid[i] <= 1'b0;
        btb_cnt[i]   <= 2'b01;
      end
    end else if (upd_en) begin
      if (upd_hit) begin
        if (bus.upd_taken_in) begin
          if (btb_cnt[upd_idx] != 2'b11) btb_cnt[upd_idx] <= btb_cnt[upd_idx] + 2'b01;
        end else begin
          if (btb_cnt[upd_idx] != 2'b00) btb_cnt[upd_idx] <= btb_cnt[upd_idx] - 2'b01;
        end
      end else if (bus.upd_taken_in) begin
        btb_valid[upd_idx] <= 1'b1;
        btb_cnt[upd_idx]   <= 2'b10;
      end
    end
  end

  // Tag and target carry no reset; the valid bit guards them
  always_ff @(posedge clk_in) begin
    if (rst_in && upd_en && bus.upd_taken_in) begin
      btb_target[upd_idx] <= bus.upd_target_in;
      if (!upd_hit) btb_tag[upd_idx] <= upd_tag;
    end
  end
endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: fetch sequence, BTB training, redirect priority,
// rdy freeze, alias replacement, wrap and mid-run reset.
module tb_pc_gen;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pc_gen_if #(.ADDR_W(ADDR_W), .STALL_W(6)) bus ();

  pc_gen #(
    .ADDR_W   (ADDR_W),
    .RESET_VEC(32'h0),
    .BTB_DEPTH(16),
    .STALL_W  (6)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [ADDR_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [ADDR_W-1:0] obs, input logic [ADDR_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.rdy_in = 1'b1;
    bus.stall = '0;
    bus.branch_flag_in = 1'b0;
    bus.branch_target_addr_in = '0;
    bus.upd_valid_in = 1'b0;
    bus.upd_pc_in = '0;
    bus.upd_target_in = '0;
    bus.upd_taken_in = 1'b0;
  endtask

  task automatic redirect(input logic [ADDR_W-1:0] addr);
    bus.branch_flag_in = 1'b1;
    bus.branch_target_addr_in = addr;
    step();
    bus.branch_flag_in = 1'b0;
  endtask

  task automatic update(input logic [ADDR_W-1:0] upc, input logic [ADDR_W-1:0] tgt, input logic taken);
    bus.upd_valid_in = 1'b1;
    bus.upd_pc_in = upc;
    bus.upd_target_in = tgt;
    bus.upd_taken_in = taken;
    step();
    bus.upd_valid_in = 1'b0;
  endtask

  initial begin
    drive_idle();
    step();
    step();
    check("reset_pc", bus.pc_out, 32'h0);
    check("reset_pred", {31'b0, bus.pred_taken_out}, 32'h0);

    // Sequential fetch, with the 0x10 entry trained while fetching 0x0
    rst = 1'b1;
    exp_q = {32'h4, 32'h8, 32'hC, 32'h10};
    update(32'h10, 32'h100, 1'b1);
    check("seq", bus.pc_out, exp_q.pop_front());
    for (int i = 0; i < 3; i++) begin
      step();
      check("seq", bus.pc_out, exp_q.pop_front());
    end
    check("hit_pred", {31'b0, bus.pred_taken_out}, 32'h1);
    check("hit_target", bus.pred_target_out, 32'h100);
    step();
    check("pred_follow", bus.pc_out, 32'h100);

    // Two not-taken updates: counter 10 -> 01 -> 00
    step();
    update(32'h10, 32'h0, 1'b0);
    update(32'h10, 32'h0, 1'b0);
    check("nt_pc", bus.pc_out, 32'h10C);
    redirect(32'h10);
    check("nt_pred", {31'b0, bus.pred_taken_out}, 32'h0);
    step();
    check("nt_seq", bus.pc_out, 32'h14);

    // Retrain taken twice with a new target: 00 -> 01 -> 10
    update(32'h10, 32'h180, 1'b1);
    update(32'h10, 32'h180, 1'b1);
    redirect(32'h10);
    check("retrain_pred", {31'b0, bus.pred_taken_out}, 32'h1);
    check("retrain_target", bus.pred_target_out, 32'h180);

    // Redirect beats stall and a BTB hit, low bits masked
    bus.stall = 6'b000001;
    redirect(32'h203);
    check("redir_stall", bus.pc_out, 32'h200);
    step();
    check("stall_hold", bus.pc_out, 32'h200);
    bus.stall = '0;

    // rdy_in=0 freezes PC and BTB
    bus.rdy_in = 1'b0;
    step();
    bus.branch_flag_in = 1'b1;
    bus.branch_target_addr_in = 32'h40;
    update(32'h10, 32'h0, 1'b0);
    bus.branch_flag_in = 1'b0;
    step();
    check("rdy_hold", bus.pc_out, 32'h200);
    bus.rdy_in = 1'b1;
    redirect(32'h10);
    check("rdy_btb_pred", {31'b0, bus.pred_taken_out}, 32'h1);
    check("rdy_btb_target", bus.pred_target_out, 32'h180);

    // Alias at 0x50 replaces 0x10; same-cycle lookup still sees old entry
    update(32'h50, 32'h400, 1'b1);
    check("old_lookup", bus.pc_out, 32'h180);
    redirect(32'h10);
    check("alias_evict", {31'b0, bus.pred_taken_out}, 32'h0);
    step();
    check("alias_seq", bus.pc_out, 32'h14);
    redirect(32'h50);
    check("alias_pred", {31'b0, bus.pred_taken_out}, 32'h1);
    step();
    check("alias_follow", bus.pc_out, 32'h400);

    // Wrap at the top of the address space
    redirect(32'hFFFF_FFFF);
    check("mask_top", bus.pc_out, 32'hFFFF_FFFC);
    step();
    check("wrap", bus.pc_out, 32'h0);

    // Reset mid-run discards redirect and update, clears valid bits
    rst = 1'b0;
    bus.branch_flag_in = 1'b1;
    bus.branch_target_addr_in = 32'h700;
    update(32'h20, 32'h500, 1'b1);
    bus.branch_flag_in = 1'b0;
    check("mid_reset_pc", bus.pc_out, 32'h0);
    rst = 1'b1;
    redirect(32'h50);
    check("reset_clr_50", {31'b0, bus.pred_taken_out}, 32'h0);
    redirect(32'h20);
    check("reset_drop_upd", {31'b0, bus.pred_taken_out}, 32'h0);

    // Saturation at 3: 10,11,11 then one not-taken leaves 10
    update(32'h10, 32'h100, 1'b1);
    update(32'h10, 32'h100, 1'b1);
    update(32'h10, 32'h100, 1'b1);
    update(32'h10, 32'h100, 1'b0);
    redirect(32'h10);
    check("sat_pred", {31'b0, bus.pred_taken_out}, 32'h1);
    check("sat_target", bus.pred_target_out, 32'h100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
